// File: rtl/i_cache_2way_pkg.sv
// rtl/i_cache_2way_pkg.sv - shared types, default geometry and width helpers for the 2-way i-cache
package i_cache_2way_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_e;

    localparam int DEF_A_WIDTH  = 32;
    localparam int DEF_C_INDEX  = 7;
    localparam int DEF_C_OFFSET = 2;
    localparam int T_WIDTH      = DEF_A_WIDTH - DEF_C_INDEX - DEF_C_OFFSET - 2;
    localparam int LINE_WORDS   = 2 ** DEF_C_OFFSET;

    function automatic int tag_width(input int a_width, input int c_index, input int c_offset);
        return a_width - c_index - c_offset - 2;
    endfunction

    // A one-word line still needs a 1-bit word/counter signal to stay legal
    function automatic int word_bits(input int c_offset);
        return (c_offset == 0) ? 1 : c_offset;
    endfunction

endpackage

// File: rtl/i_cache_way.sv
// rtl/i_cache_way.sv - one cache way: valid/tag/data arrays, tag compare and word select
module i_cache_way #(
    parameter int T_W      = 21,
    parameter int C_INDEX  = 7,
    parameter int C_OFFSET = 2,
    parameter int OW       = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [C_INDEX-1:0] rd_index_i,
    input  logic [T_W-1:0]     rd_tag_i,
    input  logic [OW-1:0]      rd_word_i,
    output logic               valid_o,
    output logic               hit_o,
    output logic [31:0]        data_o,
    input  logic               wr_en_i,
    input  logic [C_INDEX-1:0] wr_index_i,
    input  logic [OW-1:0]      wr_word_i,
    input  logic [31:0]        wr_data_i,
    input  logic               inval_i,
    input  logic               install_i,
    input  logic [T_W-1:0]     wr_tag_i
);
    localparam int SETS = 2 ** C_INDEX;
    localparam int LW   = 2 ** C_OFFSET;

    logic [SETS-1:0] valid_q;
    logic [T_W-1:0]  tag_q  [SETS];
    logic [31:0]     data_q [SETS][LW];

    assign valid_o = valid_q[rd_index_i];
    assign hit_o   = valid_o && (tag_q[rd_index_i] == rd_tag_i);
    assign data_o  = data_q[rd_index_i][rd_word_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            if (install_i) begin
                valid_q[wr_index_i] <= 1'b1;
            end else if (inval_i) begin
                valid_q[wr_index_i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[wr_index_i][wr_word_i] <= wr_data_i;
            if (install_i) begin
                tag_q[wr_index_i] <= wr_tag_i;
            end
        end
    end

endmodule

// File: rtl/i_cache_2way.sv
// rtl/i_cache_2way.sv - 2-way set-associative instruction cache with LRU and word-serial refill
module i_cache_2way
    import i_cache_2way_pkg::*;
#(
    parameter int A_WIDTH  = 32,
    parameter int C_INDEX  = 7,
    parameter int C_OFFSET = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_WIDTH-1:0] p_a,
    input  logic               p_strobe,
    input  logic               p_flush,
    output logic [31:0]        p_din,
    output logic               p_ready,
    output logic               cache_miss,
    output logic [A_WIDTH-1:0] m_a,
    output logic               m_strobe,
    input  logic [31:0]        m_dout,
    input  logic               m_ready
);
    localparam int TW   = tag_width(A_WIDTH, C_INDEX, C_OFFSET);
    localparam int LW   = 2 ** C_OFFSET;
    localparam int OW   = word_bits(C_OFFSET);
    localparam int SETS = 2 ** C_INDEX;

    logic [TW-1:0]      tag;
    logic [C_INDEX-1:0] index;
    logic [OW-1:0]      word;

    state_e             state_q, state_d;
    logic [OW-1:0]      cnt_q;
    logic [A_WIDTH-1:0] base_q;
    logic [TW-1:0]      tag_q;
    logic [C_INDEX-1:0] index_q;
    logic               victim_q;
    logic               cancel_q;
    logic [SETS-1:0]    lru_q;

    logic [1:0]  valid_w, hit_w;
    logic [31:0] data_w [2];
    logic        hit, hit_way, victim, fill_word, fill_last, start_refill;

    assign tag   = p_a[A_WIDTH-1 -: TW];
    assign index = p_a[C_OFFSET+2 +: C_INDEX];

    generate
        if (C_OFFSET > 0) begin : g_word
            assign word = p_a[C_OFFSET+1:2];
        end else begin : g_noword
            assign word = '0;
        end
    endgenerate

    assign hit          = |hit_w;
    assign hit_way      = hit_w[1];
    assign victim       = !valid_w[0] ? 1'b0 : (!valid_w[1] ? 1'b1 : lru_q[index]);
    assign fill_word    = (state_q == ST_REFILL) && m_ready;
    assign fill_last    = fill_word && (cnt_q == OW'(LW - 1));
    assign start_refill = (state_q == ST_IDLE) && p_strobe && !hit && !p_flush;

    generate
        for (genvar w = 0; w < 2; w++) begin : g_way
            i_cache_way #(
                .T_W      (TW),
                .C_INDEX  (C_INDEX),
                .C_OFFSET (C_OFFSET),
                .OW       (OW)
            ) u_way (
                .clk        (clk),
                .rst        (rst),
                .rd_index_i (index),
                .rd_tag_i   (tag),
                .rd_word_i  (word),
                .valid_o    (valid_w[w]),
                .hit_o      (hit_w[w]),
                .data_o     (data_w[w]),
                .wr_en_i    (fill_word && (victim_q == 1'(w))),
                .wr_index_i (index_q),
                .wr_word_i  (cnt_q),
                .wr_data_i  (m_dout),
                .inval_i    (cnt_q == '0),
                .install_i  (fill_last),
                .wr_tag_i   (tag_q)
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_refill) state_d = ST_REFILL;
            ST_REFILL: if (fill_last)    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced to their idle values while rst is high, not only after the edge
    always_comb begin
        p_ready    = 1'b0;
        m_strobe   = 1'b0;
        cache_miss = 1'b1;
        m_a        = '0;
        p_din      = hit_way ? data_w[1] : data_w[0];
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    cache_miss = !hit;
                    p_ready    = p_strobe && hit && !cancel_q;
                end
                ST_REFILL: begin
                    m_strobe = 1'b1;
                    m_a      = base_q + A_WIDTH'({cnt_q, 2'b00});
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            cancel_q <= 1'b0;
            lru_q    <= '0;
            base_q   <= '0;
            tag_q    <= '0;
            index_q  <= '0;
            victim_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            cancel_q <= 1'b0;
            if (p_ready) begin
                lru_q[index] <= !hit_way;
            end
            if (start_refill) begin
                base_q   <= {p_a[A_WIDTH-1:C_OFFSET+2], (C_OFFSET+2)'(0)};
                tag_q    <= tag;
                index_q  <= index;
                victim_q <= victim;
                cnt_q    <= '0;
            end
        end else begin
            if (p_flush) begin
                cancel_q <= 1'b1;
            end
            if (fill_word) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (fill_last) begin
                lru_q[index_q] <= !victim_q;
            end
        end
    end

endmodule
